// File: rtl/vx_slot_sched_pkg.sv
// Shared types and constants for the vx_slot_scheduler holding buffer.
package vx_slot_sched_pkg;

  localparam int PERF_W = 32;

  // Per-slot control flags. The top wraps these with a payload of its own width.
  typedef struct packed {
    logic occupied;
    logic ready;
  } slot_flags_t;

  function automatic int calc_idxw(input int num_slots);
    return (num_slots > 32'sd1) ? $clog2(num_slots) : 32'sd1;
  endfunction

endpackage

// File: rtl/VX_find_first.sv
// First-valid priority selector: returns the data of the first asserted valid,
// lowest index first unless REVERSE is set.
module VX_find_first #(
  parameter int N       = 4,
  parameter int DATAW   = 8,
  parameter int REVERSE = 0
) (
  input  logic [N-1:0]            valid_in,
  input  logic [N-1:0][DATAW-1:0] data_in,
  output logic [DATAW-1:0]        data_out,
  output logic                    valid_out
);

  // Scan from lowest to highest priority so the winning entry is written last.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < N; i++) begin
      automatic int j = (REVERSE != 32'sd0) ? i : (N - 32'sd1 - i);
      data_out = valid_in[j] ? data_in[j] : data_out;
    end
  end

  assign valid_out = |valid_in;

endmodule

// File: rtl/vx_slot_scheduler.sv
// Slot scheduler: allocates into the first free slot, wakes slots by index and
// issues the first ready slot through a registered output. Optional
// VX_SLOT_SCHED_PERF_EN adds saturating stall/issue counters.
module vx_slot_scheduler
  import vx_slot_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int DATAW     = 32,
  parameter int REVERSE   = 0,
  parameter int IDXW      = calc_idxw(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  input  logic [DATAW-1:0] alloc_data,
  input  logic             alloc_rdy,
  output logic             alloc_ready,
  output logic [IDXW-1:0]  alloc_idx,
  input  logic             wake_valid,
  input  logic [IDXW-1:0]  wake_idx,
  output logic             issue_valid,
  output logic [DATAW-1:0] issue_data,
  output logic [IDXW-1:0]  issue_idx,
  input  logic             issue_ready
`ifdef VX_SLOT_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cycles,
  output logic [PERF_W-1:0] perf_issued
`endif
);

  typedef struct packed {
    slot_flags_t      flags;
    logic [DATAW-1:0] data;
  } slot_state_t;

  slot_state_t [NUM_SLOTS-1:0]                 slots_r;
  slot_state_t [NUM_SLOTS-1:0]                 slots_s;
  logic        [NUM_SLOTS-1:0]                 free_mask_s;
  logic        [NUM_SLOTS-1:0]                 cand_mask_s;
  logic        [NUM_SLOTS-1:0][IDXW-1:0]       free_data_s;
  logic        [NUM_SLOTS-1:0][IDXW+DATAW-1:0] cand_data_s;
  logic        [IDXW-1:0]                      free_sel_s;
  logic        [IDXW+DATAW-1:0]                cand_sel_s;
  logic                                        free_any_s;
  logic                                        cand_any_s;
  logic                                        load_en_s;
  logic                                        alloc_fire_s;
  logic                                        issue_load_s;
  logic        [IDXW-1:0]                      cand_idx_s;

  // Build selector inputs from registered slot state only.
  always_comb begin
    free_mask_s = '0;
    cand_mask_s = '0;
    free_data_s = '0;
    cand_data_s = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      free_mask_s[i] = ~slots_r[i].flags.occupied;
      cand_mask_s[i] = slots_r[i].flags.occupied & slots_r[i].flags.ready;
      free_data_s[i] = IDXW'(i);
      cand_data_s[i] = {IDXW'(i), slots_r[i].data};
    end
  end

  VX_find_first #(
    .N       (NUM_SLOTS),
    .DATAW   (IDXW),
    .REVERSE (REVERSE)
  ) u_free_sel (
    .valid_in  (free_mask_s),
    .data_in   (free_data_s),
    .data_out  (free_sel_s),
    .valid_out (free_any_s)
  );

  VX_find_first #(
    .N       (NUM_SLOTS),
    .DATAW   (IDXW + DATAW),
    .REVERSE (REVERSE)
  ) u_issue_sel (
    .valid_in  (cand_mask_s),
    .data_in   (cand_data_s),
    .data_out  (cand_sel_s),
    .valid_out (cand_any_s)
  );

  assign alloc_ready  = free_any_s;
  assign alloc_idx    = free_any_s ? free_sel_s : {IDXW{1'b0}};
  assign load_en_s    = !issue_valid || issue_ready;
  assign alloc_fire_s = alloc_valid && free_any_s;
  assign issue_load_s = load_en_s && cand_any_s;
  assign cand_idx_s   = cand_sel_s[IDXW+DATAW-1:DATAW];

  // Slot next state: alloc targets a free slot and issue an occupied one, so they
  // never collide; issue clearing wins over a wake to the same slot.
  always_comb begin
    slots_s = slots_r;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (alloc_fire_s && (alloc_idx == IDXW'(i))) begin
        slots_s[i].flags.occupied = 1'b1;
        slots_s[i].flags.ready    = alloc_rdy;
        slots_s[i].data           = alloc_data;
      end else if (issue_load_s && (cand_idx_s == IDXW'(i))) begin
        slots_s[i].flags.occupied = 1'b0;
        slots_s[i].flags.ready    = 1'b0;
      end else if (wake_valid && (wake_idx == IDXW'(i)) && slots_r[i].flags.occupied) begin
        slots_s[i].flags.ready    = 1'b1;
      end else begin
        slots_s[i] = slots_r[i];
      end
    end
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      slots_r <= '0;
    end else begin
      slots_r <= slots_s;
    end
  end

  // Output stage: refill whenever empty or draining, hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_valid <= 1'b0;
      issue_data  <= '0;
      issue_idx   <= '0;
    end else if (load_en_s) begin
      issue_valid <= cand_any_s;
      if (cand_any_s) begin
        issue_data <= cand_sel_s[DATAW-1:0];
        issue_idx  <= cand_idx_s;
      end
    end
  end

`ifdef VX_SLOT_SCHED_PERF_EN
  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_issued       <= '0;
    end else begin
      if (alloc_valid && !alloc_ready && (perf_stall_cycles != {PERF_W{1'b1}})) begin
        perf_stall_cycles <= perf_stall_cycles + PERF_W'(1);
      end
      if (issue_valid && issue_ready && (perf_issued != {PERF_W{1'b1}})) begin
        perf_issued <= perf_issued + PERF_W'(1);
      end
    end
  end
`else
  // Counters are absent from the default build.
`endif

endmodule
